activation_unit: RTL and testbench

//  Responder end of the activation handshake driven by the forward-propagation sequencer.

---
 rtl/act_pkg.sv | 29 ++
 rtl/pla_sigmoid_core.sv | 26 ++
 rtl/activation_unit.sv | 137 +++++++++++++
 tb/tb_activation_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// Shared encodings and Q8.8 constants for the activation unit.
package act_pkg;

  // Function select encoding on activate_ctrl
  typedef enum logic [1:0] {
    ACT_SIGMOID = 2'b00,
    ACT_TANH    = 2'b01,
    ACT_RELU    = 2'b10,
    ACT_IDENT   = 2'b11
  } act_fn_e;

  // One-hot-free 3-bit state encoding; every non-idle state lasts one cycle
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_EVAL = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } act_state_e;

  // Q8.8 constants (value * 256)
  localparam logic [15:0] ONE         = 16'h0100; // 1.0
  localparam logic [15:0] BP_5_0      = 16'h0500; // 5.0
  localparam logic [15:0] BP_2_375    = 16'h0260; // 2.375
  localparam logic [15:0] OFF_0_84375 = 16'h00D8; // 0.84375
  localparam logic [15:0] OFF_0_625   = 16'h00A0; // 0.625
  localparam logic [15:0] HALF        = 16'h0080; // 0.5

endpackage

// File: rtl/pla_sigmoid_core.sv
// Piecewise-linear sigmoid on a non-negative magnitude: segment select plus
// a single shift and add, no multiplier. Shared by sigmoid and tanh.
module pla_sigmoid_core
  import act_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] y
);

  // Pick the segment and form slope*a + offset with a right shift
  always_comb begin
    y = DATA_W'(ONE);
    if (a >= DATA_W'(BP_5_0)) begin
      y = DATA_W'(ONE);
    end else if (a >= DATA_W'(BP_2_375)) begin
      y = (a >> 5) + DATA_W'(OFF_0_84375);
    end else if (a >= DATA_W'(ONE)) begin
      y = (a >> 3) + DATA_W'(OFF_0_625);
    end else begin
      y = (a >> 2) + DATA_W'(HALF);
    end
  end

endmodule

// File: rtl/activation_unit.sv
// Responder for the activation handshake: captures one Q8.8 operand, runs it
// through PREP/EVAL/POST/DONE (one cycle each) and pulses activate_ready.
module activation_unit
  import act_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              act_valid,
  input  logic [DATA_W-1:0] activate_in,
  input  logic [1:0]        activate_ctrl,
  output logic              activate_ready,
  output logic [DATA_W-1:0] activate_out,
  output logic              act_busy
);

  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] K_ONE   = DATA_W'(ONE);

  act_state_e        state_q, state_d;
  act_fn_e           fn_q, fn_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic              sign_q, sign_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] core_y;
  logic [DATA_W-1:0] abs_x;
  logic [DATA_W-1:0] tanh_t;

  pla_sigmoid_core #(.DATA_W(DATA_W)) u_core (
    .a (a_q),
    .y (core_y)
  );

  // Saturating magnitude; -MIN_NEG does not fit so clamp to MAX_POS
  always_comb begin
    abs_x = x_q;
    if (x_q == MIN_NEG)        abs_x = MAX_POS;
    else if (x_q[DATA_W-1])    abs_x = -x_q;
  end

  // tanh(x) = 2*sigmoid(2x) - 1, result in [0, ONE] before sign
  always_comb begin
    tanh_t = (y_q << 1) - K_ONE;
  end

  // Next-state, datapath registers and registered handshake outputs
  always_comb begin
    state_d = state_q;
    fn_d    = fn_q;
    x_d     = x_q;
    sign_d  = sign_q;
    a_d     = a_q;
    y_d     = y_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (act_valid) begin
          x_d     = activate_in;
          fn_d    = act_fn_e'(activate_ctrl);
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        sign_d = x_q[DATA_W-1];
        a_d    = abs_x;
        if (fn_q == ACT_TANH) begin
          // a <= MAX_POS, so a doubling overflows iff bit DATA_W-2 is set
          a_d = abs_x[DATA_W-2] ? MAX_POS : (abs_x << 1);
        end
        state_d = ST_EVAL;
      end
      ST_EVAL: begin
        y_d     = core_y;
        state_d = ST_POST;
      end
      ST_POST: begin
        case (fn_q)
          ACT_SIGMOID: out_d = sign_q ? (K_ONE - y_q) : y_q;
          ACT_TANH:    out_d = sign_q ? -tanh_t : tanh_t;
          ACT_RELU:    out_d = sign_q ? '0 : x_q;
          default:     out_d = x_q;
        endcase
        state_d = ST_POST == ST_POST ? ST_DONE : ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_q == ST_DONE);
  end

  // State and datapath registers; synchronous reset aborts any operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fn_q    <= ACT_SIGMOID;
      x_q     <= '0;
      sign_q  <= 1'b0;
      a_q     <= '0;
      y_q     <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fn_q    <= fn_d;
      x_q     <= x_d;
      sign_q  <= sign_d;
      a_q     <= a_d;
      y_q     <= y_d;
      out_q   <= out_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign activate_ready = ready_q;
  assign activate_out   = out_q;
  assign act_busy       = busy_q;

  // FRAC_W documents the Q format; the constants above are fixed Q8.8
  logic unused_frac;
  assign unused_frac = (FRAC_W == 8);

endmodule

// File: tb/tb_activation_unit.sv
// Scoreboard bench for activation_unit: expected values are queued when a
// request is driven and popped when activate_ready pulses.
module tb_activation_unit;

  logic        clk;
  logic        rst;
  logic        act_valid;
  logic [15:0] activate_in;
  logic [1:0]  activate_ctrl;
  logic        activate_ready;
  logic [15:0] activate_out;
  logic        act_busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] val;
    logic [1:0]  c;
    logic [15:0] x;
  } exp_t;

  exp_t exp_q[$];

  activation_unit dut (
    .clk            (clk),
    .rst            (rst),
    .act_valid      (act_valid),
    .activate_in    (activate_in),
    .activate_ctrl  (activate_ctrl),
    .activate_ready (activate_ready),
    .activate_out   (activate_out),
    .act_busy       (act_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-exact reference written from the algorithm, in integer arithmetic
  function automatic logic [15:0] ref_act(input logic [1:0] c, input logic [15:0] x);
    int xi, a, y, r;
    logic [31:0] rv;
    xi = int'($signed(x));
    a  = (xi < 0) ? -xi : xi;
    if (a > 32767) a = 32767;
    if (c == 2'b01) begin
      a = a * 2;
      if (a > 32767) a = 32767;
    end
    if (a >= 1280)      y = 256;
    else if (a >= 608)  y = a / 32 + 216;
    else if (a >= 256)  y = a / 8 + 160;
    else                y = a / 4 + 128;
    case (c)
      2'b00:   r = (xi < 0) ? 256 - y : y;
      2'b01:   begin r = 2 * y - 256; if (xi < 0) r = -r; end
      2'b10:   r = (xi < 0) ? 0 : xi;
      default: r = xi;
    endcase
    rv = r;
    return rv[15:0];
  endfunction

  // Output monitor: every ready pulse must match the oldest queued request
  always @(negedge clk) begin
    exp_t e;
    if (activate_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: out=%h with no request outstanding", activate_out);
      end else begin
        e = exp_q.pop_front();
        if (activate_out !== e.val) begin
          errors++;
          $display("FAIL result ctrl=%0d x=%h: got %h expected %h", e.c, e.x, activate_out, e.val);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (act_busy !== 1'b0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL wait_idle_timeout: busy=%b expected 0", act_busy);
    end
  endtask

  // Drive one request and queue its expected result
  task automatic issue(input logic [1:0] c, input logic [15:0] x, input logic [15:0] e);
    exp_t ent;
    wait_idle();
    @(negedge clk);
    act_valid = 1'b1; activate_in = x; activate_ctrl = c;
    ent.val = e; ent.c = c; ent.x = x;
    exp_q.push_back(ent);
    @(posedge clk); #1;
    act_valid = 1'b0;
  endtask

  task automatic drain();
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; act_valid = 1'b0; activate_in = '0; activate_ctrl = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (activate_out !== 16'h0000 || activate_ready !== 1'b0 || act_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out=%h ready=%b busy=%b expected 0000 0 0",
               activate_out, activate_ready, act_busy);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    issue(2'b00, 16'h0000, 16'h0080);
    issue(2'b00, 16'h0100, 16'h00C0);
    issue(2'b00, 16'hFF00, 16'h0040);
    issue(2'b00, 16'h0600, 16'h0100);
    issue(2'b01, 16'h0080, 16'h0080);
    issue(2'b01, 16'hFF80, 16'hFF80);
    issue(2'b01, 16'h8000, 16'hFF00);
    issue(2'b10, 16'hFF00, 16'h0000);
    issue(2'b10, 16'h0234, 16'h0234);
    issue(2'b11, 16'h8001, 16'h8001);
    drain();
  endtask

  task automatic test_handshake();
    logic [15:0] exp_v;
    int pulses;
    exp_t ent;
    wait_idle();
    exp_v = 16'h00C0;
    @(negedge clk);
    act_valid = 1'b1; activate_in = 16'h0100; activate_ctrl = 2'b00;
    ent.val = exp_v; ent.c = 2'b00; ent.x = 16'h0100;
    exp_q.push_back(ent);
    @(posedge clk); #1;                       // edge k: accepted
    activate_in = 16'h0600; activate_ctrl = 2'b11; // re-pulse while busy
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (act_busy !== 1'b1 || activate_ready !== 1'b0) begin
        errors++;
        $display("FAIL hs_busy_k+%0d: busy=%b ready=%b expected 1 0", i, act_busy, activate_ready);
      end
      @(posedge clk); #1;
    end
    act_valid = 1'b0;                         // now after edge k+4
    checks++;
    if (act_busy !== 1'b0 || activate_ready !== 1'b1 || activate_out !== exp_v) begin
      errors++;
      $display("FAIL hs_ready_k+4: busy=%b ready=%b out=%h expected 0 1 %h",
               act_busy, activate_ready, activate_out, exp_v);
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (activate_ready === 1'b1) pulses++;
      checks++;
      if (activate_out !== exp_v || act_busy !== 1'b0) begin
        errors++;
        $display("FAIL hs_hold_%0d: out=%h busy=%b expected %h 0", i, activate_out, act_busy, exp_v);
      end
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL hs_extra_pulse: %0d extra pulses, expected 0", pulses);
    end
    drain();
  endtask

  task automatic test_reset_midop();
    int pulses;
    wait_idle();
    @(negedge clk);
    act_valid = 1'b1; activate_in = 16'h0100; activate_ctrl = 2'b00;
    @(posedge clk); #1;  // PREP
    act_valid = 1'b0;
    @(posedge clk); #1;  // EVAL
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (act_busy !== 1'b0 || activate_out !== 16'h0000 || activate_ready !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: busy=%b out=%h ready=%b expected 0 0000 0",
               act_busy, activate_out, activate_ready);
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (activate_ready === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL midop_pulse: %0d pulses after reset, expected 0", pulses);
    end
    // reset wins over a simultaneous request
    @(negedge clk);
    rst = 1'b1; act_valid = 1'b1; activate_in = 16'h0200; activate_ctrl = 2'b11;
    @(posedge clk); #1;
    rst = 1'b0; act_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (act_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_vs_valid: busy=%b expected 0", act_busy);
    end
    issue(2'b00, 16'hFF00, 16'h0040);
    drain();
  endtask

  task automatic test_boundaries();
    logic [15:0] bps[10];
    logic [15:0] x;
    bps = '{16'h00FF, 16'h0100, 16'h025F, 16'h0260, 16'h04FF, 16'h0500,
            16'h007F, 16'h0080, 16'h012F, 16'h0130};
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 10; i++) begin
        x = bps[i];
        issue(2'(c), x, ref_act(2'(c), x));
        x = -bps[i];
        issue(2'(c), x, ref_act(2'(c), x));
      end
    end
    issue(2'b00, 16'h7FFF, ref_act(2'b00, 16'h7FFF));
    issue(2'b01, 16'h8001, ref_act(2'b01, 16'h8001));
    drain();
  endtask

  task automatic test_sweep();
    logic [15:0] x;
    for (int c = 0; c < 4; c++) begin
      for (int v = 0; v < 65536; v += 257) begin
        x = 16'(v);
        issue(2'(c), x, ref_act(2'(c), x));
      end
      for (int i = 0; i < 40; i++) begin
        x = 16'($urandom_range(0, 65535));
        issue(2'(c), x, ref_act(2'(c), x));
      end
    end
    drain();
  endtask

  task automatic test_monotonic();
    logic [15:0] res, prev;
    logic [15:0] x;
    int n;
    for (int c = 0; c < 2; c++) begin
      prev = 16'h8000;
      for (int v = -32768; v < 32768; v += 128) begin
        x = 16'(v);
        issue(2'(c), x, ref_act(2'(c), x));
        n = 0;
        while (activate_ready !== 1'b1 && n < 10) begin
          @(posedge clk); #1;
          n++;
        end
        res = activate_out;
        checks++;
        if (n >= 10) begin
          errors++;
          $display("FAIL mono_timeout ctrl=%0d x=%h: no ready within 10 cycles", c, x);
        end else if ($signed(res) < $signed(prev)) begin
          errors++;
          $display("FAIL monotonic ctrl=%0d x=%h: got %h below previous %h", c, x, res, prev);
        end
        prev = res;
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_handshake();
    test_reset_midop();
    test_boundaries();
    test_sweep();
    test_monotonic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
